// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and the memory.
// The fetch stage is the master: it owns req/addr; the memory answers with ready/rdata.
interface if_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, runs the imem request handshake, honours hazard-unit stalls
// (PCWrite / IF_ID_Write) and EX branch flushes.
// Optional build macro FETCH_PERF_EN adds the fetch_stall_cnt output.
module if_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    if_fetch_stage_if.master imem,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_stall_cnt
`endif
);

    // IDLE: one cycle after reset; REQ: request out; HOLD: fetched word parked
    // while ID is stalled; DROP: flushed request still outstanding, data discarded.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

    state_t          r_state, w_state_n;
    logic [XLEN-1:0] r_pc, w_pc_n;
    logic [XLEN-1:0] r_drop_addr, w_drop_addr_n;
    logic [XLEN-1:0] r_hold, w_hold_n;
    logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_n;
    logic [XLEN-1:0] r_ifid_instr, w_ifid_instr_n;
    logic            r_ifid_valid, w_ifid_valid_n;

    logic [XLEN-1:0] w_target;
    logic            w_adv;

    assign w_target = {branch_target[XLEN-1:2], 2'b00};
    assign w_adv    = IF_ID_Write & PCWrite;

    // The stale address is re-presented in DROP so the memory sees a stable request.
    assign imem.imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem.imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign IF_ID_pc    = r_ifid_pc;
    assign IF_ID_instr = r_ifid_instr;
    assign IF_ID_valid = r_ifid_valid;

    // Next-state, PC and IF/ID selection; a flush always wins over a stall.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_drop_addr_n  = r_drop_addr;
        w_hold_n       = r_hold;
        w_ifid_pc_n    = r_ifid_pc;
        w_ifid_instr_n = r_ifid_instr;
        w_ifid_valid_n = r_ifid_valid;
        case (r_state)
            S_IDLE: begin
                w_state_n = S_REQ;
                if (flush) begin
                    w_pc_n         = w_target;
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                end
            end
            S_REQ: begin
                if (flush) begin
                    w_pc_n         = w_target;
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                    if (!imem.imem_ready) begin
                        w_drop_addr_n = r_pc;
                        w_state_n     = S_DROP;
                    end
                end else if (imem.imem_ready) begin
                    if (w_adv) begin
                        w_ifid_pc_n    = r_pc;
                        w_ifid_instr_n = imem.imem_rdata;
                        w_ifid_valid_n = 1'b1;
                        w_pc_n         = r_pc + XLEN'(4);
                    end else begin
                        w_hold_n  = imem.imem_rdata;
                        w_state_n = S_HOLD;
                    end
                end else if (IF_ID_Write) begin
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_pc_n         = w_target;
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                    w_state_n      = S_REQ;
                end else if (w_adv) begin
                    w_ifid_pc_n    = r_pc;
                    w_ifid_instr_n = r_hold;
                    w_ifid_valid_n = 1'b1;
                    w_pc_n         = r_pc + XLEN'(4);
                    w_state_n      = S_REQ;
                end
            end
            S_DROP: begin
                if (flush) begin
                    w_pc_n         = w_target;
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                end else if (IF_ID_Write) begin
                    w_ifid_instr_n = NOP_INSTR;
                    w_ifid_valid_n = 1'b0;
                end
                if (imem.imem_ready) begin
                    w_state_n = S_REQ;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State, PC, hold buffer and IF/ID register; reset is asynchronous so
    // imem_req drops the moment reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drop_addr  <= '0;
            r_hold       <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_drop_addr  <= w_drop_addr_n;
            r_hold       <= w_hold_n;
            r_ifid_pc    <= w_ifid_pc_n;
            r_ifid_instr <= w_ifid_instr_n;
            r_ifid_valid <= w_ifid_valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    logic        w_stall_evt;
    logic [31:0] r_stall_cnt;

    // A stall cycle is one where a fetched word sits unissued because ID cannot accept it.
    assign w_stall_evt = !flush && !w_adv &&
                         ((r_state == S_HOLD) || ((r_state == S_REQ) && imem.imem_ready));

    // Saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != 32'hFFFFFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized stalls/flushes/ready checked every cycle against a
// behavioural model of the fetch stream.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b0;
    logic        IF_ID_Write = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;

    if_fetch_stage_if #(.XLEN(32)) bus ();

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem          (bus.master),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: next PC to fetch, an optional fetched-but-unissued word, an
    // optional outstanding request whose data must be thrown away, and IF/ID.
    logic [31:0] m_pc, m_held, m_stale_addr, m_ifid_pc, m_ifid_instr;
    bit          m_started, m_held_v, m_stale, m_ifid_valid;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_held = '0; m_stale_addr = '0;
        m_ifid_pc = '0; m_ifid_instr = NOP;
        m_started = 0; m_held_v = 0; m_stale = 0; m_ifid_valid = 0;
    endtask

    task automatic bubble();
        m_ifid_instr = NOP;
        m_ifid_valid = 0;
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = m_started && !m_held_v;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
        chk("IF_ID_pc", IF_ID_pc, m_ifid_pc);
        chk("IF_ID_instr", IF_ID_instr, m_ifid_instr);
        chk("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, m_ifid_valid});
    endtask

    // Apply one cycle of inputs, advance the model, clock, and compare.
    task automatic step(input bit pcw, input bit ifw, input bit fl,
                        input logic [31:0] tgt, input bit rdy);
        logic [31:0] a, t;
        bit adv;
        a   = m_stale ? m_stale_addr : m_pc;
        t   = {tgt[31:2], 2'b00};
        adv = pcw && ifw;
        PCWrite = pcw; IF_ID_Write = ifw; flush = fl; branch_target = tgt;
        bus.imem_ready = rdy;
        bus.imem_rdata = rdy ? mem(a) : $urandom;
        if (!m_started) begin
            m_started = 1;
            if (fl) begin m_pc = t; bubble(); end
        end else if (m_held_v) begin
            if (fl) begin
                m_pc = t; bubble(); m_held_v = 0;
            end else if (adv) begin
                m_ifid_pc = m_pc; m_ifid_instr = m_held; m_ifid_valid = 1;
                m_pc = m_pc + 4; m_held_v = 0;
            end
        end else if (m_stale) begin
            if (fl) begin m_pc = t; bubble(); end
            else if (ifw) bubble();
            if (rdy) m_stale = 0;
        end else begin
            if (fl) begin
                if (!rdy) begin m_stale = 1; m_stale_addr = m_pc; end
                m_pc = t; bubble();
            end else if (rdy) begin
                if (adv) begin
                    m_ifid_pc = m_pc; m_ifid_instr = mem(m_pc); m_ifid_valid = 1;
                    m_pc = m_pc + 4;
                end else begin
                    m_held = mem(m_pc); m_held_v = 1;
                end
            end else if (ifw) begin
                bubble();
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        PCWrite = 0; IF_ID_Write = 0; flush = 0; branch_target = '0;
        bus.imem_ready = 0; bus.imem_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        do_reset();
        chk("rst_instr", IF_ID_instr, NOP);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        // Streaming from reset, one instruction per cycle.
        step(1, 1, 0, 0, 1);
        chk("t1_addr0", bus.imem_addr, 32'h0);
        step(1, 1, 0, 0, 1);
        chk("t1_pc0", IF_ID_pc, 32'h0);
        chk("t1_valid", {31'd0, IF_ID_valid}, 32'd1);
        step(1, 1, 0, 0, 1);
        chk("t1_pc4", IF_ID_pc, 32'h4);

        // Three-cycle stall at pc=8.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t2_hold_pc", IF_ID_pc, 32'h4);
        end
        step(1, 1, 0, 0, 1);
        chk("t2_pc8", IF_ID_pc, 32'h8);
        chk("t2_instr8", IF_ID_instr, mem(32'h8));
        step(1, 1, 0, 0, 1);
        chk("t2_pc12", IF_ID_pc, 32'hC);

        // Flush while a word is parked in the hold buffer.
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h103, 0);
        chk("t3_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("t3_nop", IF_ID_instr, NOP);
        chk("t3_addr", bus.imem_addr, 32'h100);
        step(1, 1, 0, 0, 1);
        chk("t3_pc100", IF_ID_pc, 32'h100);

        // Flush with memory not ready: stale address held, its data dropped.
        step(1, 1, 1, 32'h100, 0);
        chk("t4_stale1", bus.imem_addr, 32'h104);
        step(1, 1, 0, 0, 0);
        chk("t4_stale2", bus.imem_addr, 32'h104);
        step(1, 1, 0, 0, 1);
        chk("t4_drop_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("t4_newaddr", bus.imem_addr, 32'h100);
        step(1, 1, 0, 0, 1);
        chk("t4_pc100", IF_ID_pc, 32'h100);

        // Flush together with a stall.
        step(0, 0, 1, 32'h40, 1);
        chk("t5_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("t5_addr", bus.imem_addr, 32'h40);

        // PC wrap, then async reset in the middle of a request.
        step(1, 1, 1, 32'hFFFFFFFC, 1);
        step(1, 1, 0, 0, 1);
        chk("t6_pcmax", IF_ID_pc, 32'hFFFFFFFC);
        chk("t6_wrap", bus.imem_addr, 32'h0);
        bus.imem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("t6_async_valid", {31'd0, IF_ID_valid}, 32'd0);

        // Randomized traffic.
        do_reset();
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
                 $urandom, ($urandom % 10) < 7);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
